paddle_drive_arbiter: RTL and testbench
=======================================

# paddle_drive_arbiter

Arbitrates the left/right drive inputs of one paddle between the player's buttons and a built-in autopilot that tracks a target horizontal position, normally the ball centre. It sits between the board button inputs and the paddle block, takes the paddle's reported edges as feedback, and produces the paddle's `right` and `left` inputs. After a configurable number of frames with no button activity, control passes to the autopilot (attract/demo mode). Any press hands control back to the player after a short holdoff.

## Interface
Parameters:
- `HRES`, 1280, horizontal resolution; clamps the target position.
- `IDLE_FRAMES`, 600, number of consecutive idle frames before entering AUTO (10 s at 60 Hz).
- `HOLDOFF_FRAMES`, 2, number of frames with both drive outputs low when handing AUTO back to HUMAN.
- `DEADBAND`, 8, autopilot dead zone in pixels, ±, around the paddle centre.

Ports:
- `pixel_clk` in 1: single clock. One clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `fsync` in 1: one-cycle frame strobe, shared with the paddle block.
- `btn_right` in 1: raw asynchronous button.
- `btn_left` in 1: raw asynchronous button.
- `force_auto` in 1: level signal; while high, the block is held in AUTO.
- `target_hpos` in 12: target x position, unsigned.
- `lhpos_in` in 12: paddle left edge, from the paddle.
- `rhpos_in` in 12: paddle right edge, from the paddle.
- `right` out 1: drive output to the paddle `right` input, registered.
- `left` out 1: drive output to the paddle `left` input, registered.
- `mode` out 2: current state, encoded HUMAN=0, AUTO=1, HOLDOFF=2.
- `auto_active` out 1: high when `mode`==AUTO.

## Operation
- **Button synchronisation.** Each button passes through a 2-FF synchroniser. `press` = `btn_r_s | btn_l_s`.
- **Activity flag.** `seen` is set by any `press` cycle. It is cleared on `fsync`, after being sampled on that same cycle.
- **Idle counter.** On `fsync`:
  - If `seen` or `press`, the counter clears to 0.
  - Otherwise it increments, saturating at `IDLE_FRAMES`.
- **State machine.** Transitions are evaluated on every cycle:
  - HUMAN -> AUTO on `fsync` when the counter would reach `IDLE_FRAMES`. Also HUMAN -> AUTO on any cycle where `force_auto`=1.
  - AUTO -> HOLDOFF on the first cycle `press`=1 while `force_auto`=0. The holdoff counter loads `HOLDOFF_FRAMES` and the idle counter clears.
  - HOLDOFF counts down one per `fsync`. It goes to HUMAN on the `fsync` at which the count is 1. If `force_auto` rises, it goes to AUTO immediately.
  - `HOLDOFF_FRAMES`=0 means AUTO goes directly to HUMAN.
- **HUMAN drive.** `right` = `btn_r_s & ~btn_l_s`; `left` = `btn_l_s & ~btn_r_s`. Both buttons pressed drives neither output.
- **AUTO drive.**
  - `centre` = (`lhpos_in` + `rhpos_in`) >> 1, computed at 13 bits so no overflow occurs.
  - `tgt` = min(`target_hpos`, `HRES`-1).
  - `err` = `tgt` − `centre` as a 13-bit signed value.
  - `err` > `DEADBAND`: `right`=1, `left`=0.
  - `err` < −`DEADBAND`: `left`=1, `right`=0.
  - Otherwise both outputs are 0.
  - The decision is latched only on `fsync`, so the outputs are constant for the whole frame.
- **HOLDOFF drive.** `right`=`left`=0.
- **Mutual exclusion.** `right` and `left` are never both high, in any state.

## Timing
- **Reset.** One cycle of `rst` gives: `right`=0, `left`=0, `mode`=HUMAN, `auto_active`=0, idle counter 0, `seen`=0, holdoff counter 0, synchronisers 0. Reset mid-frame or mid-HOLDOFF behaves identically.
- **HUMAN latency.** From a button edge to `right`/`left` takes 3 cycles: 2 synchroniser cycles plus 1 output register cycle.
- **AUTO latency.**
  - Outputs update on the cycle after `fsync`.
  - They reflect the `lhpos_in`/`rhpos_in`/`target_hpos` values sampled on the `fsync` cycle, which are pre-move values for that frame.
  - The paddle registers the drive during the frame and moves on the following `fsync`.
- **State change and outputs.** A state change takes effect on the drive outputs in the same cycle as the `mode` change. On entering AUTO, the outputs are 0 until the first `fsync` decision.
- **`press` and `fsync` together.** When `press` and `fsync` coincide, activity wins: the counter clears and no AUTO entry occurs.
- **`force_auto` falling.** When `force_auto` falls while in AUTO, the block stays in AUTO until a press.

## Structure
- **Shared package `gatorga_pkg`:**
  - `typedef enum logic [1:0] {HUMAN, AUTO, HOLDOFF} drive_mode_t`.
  - The `PUT`/`LEFT`/`RIGHT` direction constants.
- **Sub-module `paddle_autopilot`:** a combinational block taking the edges, target and `DEADBAND`, and producing `dir` (2 bits). It is instantiated once. The FSM, counters and synchronisers stay in the top module.

## Test plan
- **Reset and HUMAN drive.** Hold `btn_right` for 10 cycles. `right` rises 3 cycles after the press and `left` stays 0. Pressing both buttons gives both outputs 0.
- **Idle entry.** Run with `IDLE_FRAMES`=4, no presses, and 5 `fsync` pulses. `mode`=AUTO after the 4th `fsync`. A single press during frame 3 restarts the count.
- **Tracking.** In AUTO with `lhpos_in`=540, `rhpos_in`=740 (centre 640):
  - `target_hpos`=700 -> `right`=1 after the next `fsync`.
  - `target_hpos`=645 -> both 0.
  - `target_hpos`=600 -> `left`=1.
  - `target_hpos`=4000 -> clamped to 1279, so `right`=1.
- **Handback.** In AUTO, press `btn_left`. `mode`=HOLDOFF with outputs 0 for exactly 2 `fsync` pulses, then HUMAN and `left`=1.
- **Forced mode.** Raise `force_auto` during HOLDOFF -> AUTO on the next cycle. Presses are ignored while it is high.
- **Reset mid-AUTO.** Assert `rst` with `right`=1 -> all outputs 0 and `mode`=HUMAN on the next cycle.

Source files
------------

// File: rtl/gatorga_pkg.sv
// Shared types for the gatorga paddle blocks: drive-mode encoding and the
// direction codes the autopilot hands to the drive arbiter.
package gatorga_pkg;

  typedef enum logic [1:0] {
    HUMAN   = 2'd0,
    AUTO    = 2'd1,
    HOLDOFF = 2'd2
  } drive_mode_t;

  typedef logic [1:0] dir_t;

  localparam dir_t PUT   = 2'd0;
  localparam dir_t LEFT  = 2'd1;
  localparam dir_t RIGHT = 2'd2;

endpackage

// File: rtl/paddle_autopilot.sv
// Combinational autopilot: steers the paddle centre towards a clamped target
// x position, holding still inside a +/-DEADBAND window.
module paddle_autopilot
  import gatorga_pkg::*;
#(
  parameter int HRES     = 1280,
  parameter int DEADBAND = 8
) (
  input  logic [11:0] lhpos,
  input  logic [11:0] rhpos,
  input  logic [11:0] target_hpos,
  output dir_t        dir
);

  localparam logic [11:0]        TGT_MAX = 12'(HRES - 1);
  localparam logic signed [12:0] DB      = 13'(DEADBAND);

  logic [12:0]        edge_sum;
  logic [12:0]        centre;
  logic [11:0]        tgt;
  logic signed [12:0] err;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a signal unassigned and infer a latch.
  always_comb begin
    edge_sum = {1'b0, lhpos} + {1'b0, rhpos};
    centre   = edge_sum >> 1;
    tgt      = (target_hpos > TGT_MAX) ? TGT_MAX : target_hpos;
    // Both operands are at most 4095, so a 13-bit signed difference is exact.
    err      = $signed({1'b0, tgt}) - $signed(centre);
    dir      = PUT;
    if (err > DB)       dir = RIGHT;
    else if (err < -DB) dir = LEFT;
  end

endmodule

// File: rtl/paddle_drive_arbiter.sv
// Chooses between player buttons and the autopilot for one paddle's
// right/left drive, with idle-timeout entry to AUTO and a holdoff on handback.
module paddle_drive_arbiter
  import gatorga_pkg::*;
#(
  parameter int HRES           = 1280,
  parameter int IDLE_FRAMES    = 600,
  parameter int HOLDOFF_FRAMES = 2,
  parameter int DEADBAND       = 8
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        fsync,
  input  logic        btn_right,
  input  logic        btn_left,
  input  logic        force_auto,
  input  logic [11:0] target_hpos,
  input  logic [11:0] lhpos_in,
  input  logic [11:0] rhpos_in,
  output logic        right,
  output logic        left,
  output logic [1:0]  mode,
  output logic        auto_active
);

  localparam int IW = $clog2(IDLE_FRAMES + 1);
  localparam int HW = $clog2(HOLDOFF_FRAMES + 2);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_FRAMES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_FRAMES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);

  drive_mode_t   state, state_next;
  logic [IW-1:0] idle_cnt, idle_next, idle_inc;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          btn_r_meta, btn_r_s, btn_l_meta, btn_l_s;
  logic          seen, press, activity;
  logic          right_next, left_next;
  dir_t          dir;

  paddle_autopilot #(
    .HRES     (HRES),
    .DEADBAND (DEADBAND)
  ) u_autopilot (
    .lhpos       (lhpos_in),
    .rhpos       (rhpos_in),
    .target_hpos (target_hpos),
    .dir         (dir)
  );

  always_comb begin
    press      = btn_r_s | btn_l_s;
    activity   = seen | press;
    idle_inc   = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
    state_next = state;
    idle_next  = idle_cnt;
    hold_next  = hold_cnt;
    right_next = 1'b0;
    left_next  = 1'b0;

    if (fsync) idle_next = activity ? '0 : idle_inc;

    unique case (state)
      HUMAN: begin
        if (force_auto)
          state_next = AUTO;
        else if (fsync && !activity && idle_inc == IDLE_MAX)
          state_next = AUTO;
      end
      AUTO: begin
        if (press && !force_auto) begin
          idle_next = '0;
          if (HOLDOFF_FRAMES == 0) begin
            state_next = HUMAN;
          end else begin
            state_next = HOLDOFF;
            hold_next  = HOLD_LOAD;
          end
        end
      end
      HOLDOFF: begin
        if (force_auto) begin
          state_next = AUTO;
        end else if (fsync) begin
          hold_next = hold_cnt - 1'b1;
          if (hold_cnt == HOLD_LAST) state_next = HUMAN;
        end
      end
      default: state_next = HUMAN;
    endcase

    // Drive follows the next state so outputs and mode change together.
    unique case (state_next)
      HUMAN: begin
        right_next = btn_r_s & ~btn_l_s;
        left_next  = btn_l_s & ~btn_r_s;
      end
      AUTO: begin
        if (state == AUTO) begin
          right_next = right;
          left_next  = left;
          if (fsync) begin
            right_next = (dir == RIGHT);
            left_next  = (dir == LEFT);
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state      <= HUMAN;
      idle_cnt   <= '0;
      hold_cnt   <= '0;
      seen       <= 1'b0;
      btn_r_meta <= 1'b0;
      btn_r_s    <= 1'b0;
      btn_l_meta <= 1'b0;
      btn_l_s    <= 1'b0;
      right      <= 1'b0;
      left       <= 1'b0;
    end else begin
      state      <= state_next;
      idle_cnt   <= idle_next;
      hold_cnt   <= hold_next;
      seen       <= fsync ? 1'b0 : (seen | press);
      btn_r_meta <= btn_right;
      btn_r_s    <= btn_r_meta;
      btn_l_meta <= btn_left;
      btn_l_s    <= btn_l_meta;
      right      <= right_next;
      left       <= left_next;
    end
  end

  assign mode        = state;
  assign auto_active = (state == AUTO);

endmodule

// File: tb/tb_paddle_drive_arbiter.sv
// Self-checking bench for paddle_drive_arbiter: table-driven HUMAN and AUTO
// vectors through a scoreboard queue, plus hand sequences for mode changes.
module tb_paddle_drive_arbiter;
  import gatorga_pkg::*;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b0;
  logic        fsync = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_left = 1'b0;
  logic        force_auto = 1'b0;
  logic [11:0] target_hpos = 12'd645;
  logic [11:0] lhpos_in = 12'd540;
  logic [11:0] rhpos_in = 12'd740;
  logic        right, left, auto_active;
  logic [1:0]  mode;

  paddle_drive_arbiter #(
    .HRES           (1280),
    .IDLE_FRAMES    (4),
    .HOLDOFF_FRAMES (2),
    .DEADBAND       (8)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .fsync       (fsync),
    .btn_right   (btn_right),
    .btn_left    (btn_left),
    .force_auto  (force_auto),
    .target_hpos (target_hpos),
    .lhpos_in    (lhpos_in),
    .rhpos_in    (rhpos_in),
    .right       (right),
    .left        (left),
    .mode        (mode),
    .auto_active (auto_active)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic br;
    logic bl;
    logic r;
    logic l;
  } hum_vec_t;

  typedef struct {
    logic [11:0] lh;
    logic [11:0] rh;
    logic [11:0] tgt;
    logic        r;
    logic        l;
  } trk_vec_t;

  typedef struct {
    string      name;
    logic       r;
    logic       l;
    logic [1:0] mode;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  hum_vec_t hum_tab[4];
  trk_vec_t trk_tab[10];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge pixel_clk);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input string name, input logic r, input logic l,
                          input drive_mode_t m);
    exp_t e;
    e.name = name;
    e.r    = r;
    e.l    = l;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, want an expectation");
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".right"}, int'(right), int'(e.r));
      check({e.name, ".left"},  int'(left),  int'(e.l));
      check({e.name, ".mode"},  int'(mode),  int'(e.mode));
      check({e.name, ".auto"},  int'(auto_active), int'(e.mode == 2'(AUTO)));
    end
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    tick(1);
    fsync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hum_tab[0] = '{br: 1'b1, bl: 1'b0, r: 1'b1, l: 1'b0};
    hum_tab[1] = '{br: 1'b0, bl: 1'b1, r: 1'b0, l: 1'b1};
    hum_tab[2] = '{br: 1'b1, bl: 1'b1, r: 1'b0, l: 1'b0};
    hum_tab[3] = '{br: 1'b0, bl: 1'b0, r: 1'b0, l: 1'b0};

    // Centre of 540/740 is 640; deadband edges at 632 and 648.
    trk_tab[0] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd700,  r: 1'b1, l: 1'b0};
    trk_tab[1] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd645,  r: 1'b0, l: 1'b0};
    trk_tab[2] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd600,  r: 1'b0, l: 1'b1};
    trk_tab[3] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd4000, r: 1'b1, l: 1'b0};
    trk_tab[4] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd648,  r: 1'b0, l: 1'b0};
    trk_tab[5] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd649,  r: 1'b1, l: 1'b0};
    trk_tab[6] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd632,  r: 1'b0, l: 1'b0};
    trk_tab[7] = '{lh: 12'd540,  rh: 12'd740,  tgt: 12'd631,  r: 1'b0, l: 1'b1};
    trk_tab[8] = '{lh: 12'd100,  rh: 12'd201,  tgt: 12'd159,  r: 1'b1, l: 1'b0};
    trk_tab[9] = '{lh: 12'd4095, rh: 12'd4095, tgt: 12'd4000, r: 1'b0, l: 1'b1};

    tick(2);
    do_reset();
    push_exp("reset", 1'b0, 1'b0, HUMAN);
    sb_check();

    // HUMAN latency: right appears on the third edge after the press.
    btn_right = 1'b1;
    tick(2);
    check("lat2.right", int'(right), 0);
    tick(1);
    check("lat3.right", int'(right), 1);
    tick(7);
    check("hold10.right", int'(right), 1);
    check("hold10.left", int'(left), 0);

    foreach (hum_tab[i]) begin
      btn_right = hum_tab[i].br;
      btn_left  = hum_tab[i].bl;
      push_exp($sformatf("hum%0d", i), hum_tab[i].r, hum_tab[i].l, HUMAN);
      tick(3);
      sb_check();
    end

    // Idle entry with no activity: AUTO exactly on the 4th fsync.
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      pulse_fsync();
      check($sformatf("idle_f%0d.mode", f), int'(mode), (f >= 4) ? 1 : 0);
    end
    check("idle.auto_out_right", int'(right), 0);

    // A press during frame 3 restarts the idle count.
    do_reset();
    pulse_fsync();
    pulse_fsync();
    btn_right = 1'b1;
    tick(2);
    btn_right = 1'b0;
    tick(4);
    for (int f = 3; f <= 7; f++) begin
      pulse_fsync();
      check($sformatf("restart_f%0d.mode", f), int'(mode), (f == 7) ? 1 : 0);
    end
    push_exp("auto_entry", 1'b0, 1'b0, AUTO);
    sb_check();

    foreach (trk_tab[i]) begin
      lhpos_in    = trk_tab[i].lh;
      rhpos_in    = trk_tab[i].rh;
      target_hpos = trk_tab[i].tgt;
      push_exp($sformatf("trk%0d", i), trk_tab[i].r, trk_tab[i].l, AUTO);
      pulse_fsync();
      sb_check();
    end

    // Decision is frozen between fsyncs even as inputs move.
    lhpos_in    = 12'd540;
    rhpos_in    = 12'd740;
    target_hpos = 12'd700;
    tick(5);
    push_exp("frozen", 1'b0, 1'b1, AUTO);
    sb_check();
    push_exp("track700", 1'b1, 1'b0, AUTO);
    pulse_fsync();
    sb_check();

    // Handback: holdoff for two fsyncs, then HUMAN with left driven.
    btn_left = 1'b1;
    tick(2);
    push_exp("pre_holdoff", 1'b1, 1'b0, AUTO);
    sb_check();
    tick(1);
    push_exp("holdoff_entry", 1'b0, 1'b0, HOLDOFF);
    sb_check();
    push_exp("holdoff_f1", 1'b0, 1'b0, HOLDOFF);
    pulse_fsync();
    sb_check();
    tick(3);
    push_exp("holdoff_f2", 1'b0, 1'b1, HUMAN);
    pulse_fsync();
    sb_check();

    // force_auto: held press is ignored while high, wins over HOLDOFF.
    force_auto = 1'b1;
    push_exp("force_from_human", 1'b0, 1'b0, AUTO);
    tick(1);
    sb_check();
    tick(4);
    push_exp("force_ignores_press", 1'b0, 1'b0, AUTO);
    sb_check();
    force_auto = 1'b0;
    push_exp("force_drop_press", 1'b0, 1'b0, HOLDOFF);
    tick(1);
    sb_check();
    force_auto = 1'b1;
    push_exp("force_from_holdoff", 1'b0, 1'b0, AUTO);
    tick(1);
    sb_check();

    btn_left = 1'b0;
    tick(3);
    push_exp("force_track", 1'b1, 1'b0, AUTO);
    pulse_fsync();
    sb_check();
    force_auto = 1'b0;
    tick(3);
    push_exp("force_fall_stays", 1'b1, 1'b0, AUTO);
    sb_check();

    // Reset mid-AUTO with right driven.
    push_exp("reset_mid_auto", 1'b0, 1'b0, HUMAN);
    do_reset();
    sb_check();

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
